// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Write-side front end of the 32 x XLEN register file. Merges
//                ALU and LSU writeback results (LSU has fixed priority),
//                buffers them in a DEPTH-entry FIFO and drains at most one
//                registered write per cycle. Provides a pending-register
//                scoreboard for decode hazard checks.
//  Option      : REGWB_BYPASS_EN - when defined, o_fwd_data_k returns the
//                youngest outstanding value for query k; otherwise tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_lsu_valid,
    input  logic [4:0]      i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_data,
    output logic            o_lsu_ready,
    input  logic            i_stall,
    output logic            o_we,
    output logic [4:0]      o_write_register,
    output logic [XLEN-1:0] o_write_data,
    input  logic [4:0]      i_query_reg_1,
    input  logic [4:0]      i_query_reg_2,
    output logic            o_pending_1,
    output logic            o_pending_2,
    output logic [XLEN-1:0] o_fwd_data_1,
    output logic [XLEN-1:0] o_fwd_data_2
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] C_DEPTH = (PW + 1)'(DEPTH);

    // FIFO storage (contents are don't-care outside the valid window)
    logic [4:0]      rd_mem_q   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];

    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW:0]     count_q, count_d;
    logic            we_q, we_d;
    logic [4:0]      wreg_q, wreg_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            w_full;
    logic            w_lsu_acc;
    logic            w_alu_acc;
    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_push_rd;
    logic [XLEN-1:0] w_push_data;

    assign w_full = (count_q == C_DEPTH);

    // Ready generation and push/pop decision; an rd of x0 completes the
    // handshake but is dropped before it reaches the FIFO
    always_comb begin
        o_lsu_ready = !i_reset && !w_full;
        o_alu_ready = !i_reset && !w_full && !i_lsu_valid;
        w_lsu_acc   = i_lsu_valid && o_lsu_ready;
        w_alu_acc   = i_alu_valid && o_alu_ready;
        w_push_rd   = w_lsu_acc ? i_lsu_rd   : i_alu_rd;
        w_push_data = w_lsu_acc ? i_lsu_data : i_alu_data;
        w_push      = (w_lsu_acc || w_alu_acc) && (w_push_rd != 5'd0);
        w_pop       = !i_stall && (count_q != '0);
    end

    // Next-state for pointers, occupancy and the registered write port
    always_comb begin
        rptr_d  = rptr_q + PW'(w_pop);
        wptr_d  = wptr_q + PW'(w_push);
        count_d = count_q + (PW + 1)'(w_push) - (PW + 1)'(w_pop);
        we_d    = w_pop;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (w_pop) begin
            wreg_d  = rd_mem_q[rptr_q];
            wdata_d = data_mem_q[rptr_q];
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    // FIFO entry write; emptied logically by the count reset
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            rd_mem_q[wptr_q]   <= w_push_rd;
            data_mem_q[wptr_q] <= w_push_data;
        end
    end

    assign o_we             = we_q;
    assign o_write_register = wreg_q;
    assign o_write_data     = wdata_q;

    logic [4:0]      w_query [2];
    logic            w_pend  [2];
    logic [PW-1:0]   w_idx;
`ifdef REGWB_BYPASS_EN
    logic [XLEN-1:0] w_fwd   [2];
`endif

    assign w_query[0] = i_query_reg_1;
    assign w_query[1] = i_query_reg_2;

    // Scoreboard search: output register first, then FIFO oldest to newest,
    // so the last hit is the youngest value
    always_comb begin
        w_idx = '0;
        for (int q = 0; q < 2; q++) begin
            w_pend[q] = 1'b0;
`ifdef REGWB_BYPASS_EN
            w_fwd[q]  = '0;
`endif
            if (we_q && (wreg_q == w_query[q])) begin
                w_pend[q] = 1'b1;
`ifdef REGWB_BYPASS_EN
                w_fwd[q]  = wdata_q;
`endif
            end
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = rptr_q + PW'(k);
                if (((PW + 1)'(k) < count_q) && (rd_mem_q[w_idx] == w_query[q])) begin
                    w_pend[q] = 1'b1;
`ifdef REGWB_BYPASS_EN
                    w_fwd[q]  = data_mem_q[w_idx];
`endif
                end
            end
            if (w_query[q] == 5'd0) begin
                w_pend[q] = 1'b0;
`ifdef REGWB_BYPASS_EN
                w_fwd[q]  = '0;
`endif
            end
        end
    end

    assign o_pending_1 = w_pend[0];
    assign o_pending_2 = w_pend[1];

`ifdef REGWB_BYPASS_EN
    assign o_fwd_data_1 = w_fwd[0];
    assign o_fwd_data_2 = w_fwd[1];
`else
    assign o_fwd_data_1 = '0;
    assign o_fwd_data_2 = '0;
`endif

endmodule
`default_nettype wire
